// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the fetch/LSU-to-memory arbiter: two requester ports, one memory port.
// The slave modport is the arbiter's view; master is the surrounding requesters and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              m0_valid;
   logic              m0_ready;
   logic [ADDR_W-1:0] m0_addr;
   logic              m0_rsp_valid;
   logic [DATA_W-1:0] m0_rsp_data;

   logic              m1_valid;
   logic              m1_ready;
   logic [ADDR_W-1:0] m1_addr;
   logic              m1_we;
   logic [DATA_W-1:0] m1_wdata;
   logic [STRB_W-1:0] m1_wstrb;
   logic              m1_rsp_valid;
   logic [DATA_W-1:0] m1_rsp_data;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;

   modport slave (
      input  m0_valid, m0_addr,
      output m0_ready, m0_rsp_valid, m0_rsp_data,
      input  m1_valid, m1_addr, m1_we, m1_wdata, m1_wstrb,
      output m1_ready, m1_rsp_valid, m1_rsp_data,
      output mem_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rsp_valid, mem_rsp_data
   );

   modport master (
      output m0_valid, m0_addr,
      input  m0_ready, m0_rsp_valid, m0_rsp_data,
      output m1_valid, m1_addr, m1_we, m1_wdata, m1_wstrb,
      input  m1_ready, m1_rsp_valid, m1_rsp_data,
      input  mem_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      output mem_ready, mem_rsp_valid, mem_rsp_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (m0) and load/store (m1),
// with grant lock across stalls and an in-order ID FIFO that routes responses back.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   mem_port_arbiter_if.slave          bus,
   output logic [$clog2(MAX_OUT):0]   outstanding,
   output logic                       err_unexp_rsp
);
   localparam int STRB_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(MAX_OUT);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_OPEN  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_rr_ptr;
   logic               r_err;
   logic [MAX_OUT-1:0] r_id_fifo;
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_grant;
   logic               w_full;
   logic               w_empty;
   logic               w_mem_valid;
   logic               w_push;
   logic               w_pop;
   logic               w_head;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_we;
   logic [DATA_W-1:0]  w_wdata;
   logic [STRB_W-1:0]  w_wstrb;

   assign w_full  = (r_count == CNT_W'(MAX_OUT));
   assign w_empty = (r_count == '0);
   assign w_head  = r_id_fifo[r_rptr];

   // Lock FSM plus grant: a locked grant ignores rr_ptr until its handshake completes.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_mem_valid = 1'b0;
      unique case (r_state)
         ST_LOCK0: w_grant = 1'b0;
         ST_LOCK1: w_grant = 1'b1;
         default: begin
            if (bus.m0_valid && bus.m1_valid) w_grant = r_rr_ptr;
            else                              w_grant = bus.m1_valid;
         end
      endcase
      if (r_state != ST_OPEN) w_mem_valid = !w_full;
      else                    w_mem_valid = !w_full && (bus.m0_valid || bus.m1_valid);
      if (w_mem_valid && !bus.mem_ready)
         w_state_nxt = w_grant ? ST_LOCK1 : ST_LOCK0;
      else if (w_mem_valid && bus.mem_ready)
         w_state_nxt = ST_OPEN;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_OPEN;
      else     r_state <= w_state_nxt;
   end

   assign w_push = w_mem_valid && bus.mem_ready;
   assign w_pop  = bus.mem_rsp_valid && !w_empty;

   // Fetch requests carry no write payload, so the write fields are forced to zero.
   always_comb begin
      w_addr  = bus.m0_addr;
      w_we    = 1'b0;
      w_wdata = '0;
      w_wstrb = '0;
      if (w_grant) begin
         w_addr  = bus.m1_addr;
         w_we    = bus.m1_we;
         w_wdata = bus.m1_wdata;
         w_wstrb = bus.m1_wstrb;
      end
   end

   assign bus.mem_valid = w_mem_valid;
   assign bus.mem_addr  = w_addr;
   assign bus.mem_we    = w_we;
   assign bus.mem_wdata = w_wdata;
   assign bus.mem_wstrb = w_wstrb;
   assign bus.m0_ready  = w_push && !w_grant;
   assign bus.m1_ready  = w_push &&  w_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= 1'b0;
         r_err    <= 1'b0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_rr_ptr <= ~w_grant;
            r_wptr   <= r_wptr + PTR_W'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         if (bus.mem_rsp_valid && w_empty) r_err <= 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ID storage holds no control state; stale entries are unreachable after reset.
   always_ff @(posedge clk) begin
      if (w_push) r_id_fifo[r_wptr] <= w_grant;
   end

   assign bus.m0_rsp_valid = w_pop && !w_head;
   assign bus.m1_rsp_valid = w_pop &&  w_head;
   assign bus.m0_rsp_data  = bus.mem_rsp_data;
   assign bus.m1_rsp_data  = bus.mem_rsp_data;

   assign outstanding   = r_count;
   assign err_unexp_rsp = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: handshake, round-robin, lock, full FIFO,
// unexpected response and reset recovery.
module tb_mem_port_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] outstanding;
   logic       err_unexp_rsp;
   int         n_chk  = 0;
   int         n_pass = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .outstanding   (outstanding),
      .err_unexp_rsp (err_unexp_rsp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      bus.m0_valid      = 1'b0;
      bus.m0_addr       = '0;
      bus.m1_valid      = 1'b0;
      bus.m1_addr       = '0;
      bus.m1_we         = 1'b0;
      bus.m1_wdata      = '0;
      bus.m1_wstrb      = '0;
      bus.mem_ready     = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rsp_seq [4];
      rsp_seq[0] = 32'hA; rsp_seq[1] = 32'hB; rsp_seq[2] = 32'hC; rsp_seq[3] = 32'hD;

      idle_inputs();
      cyc();
      do_reset();
      settle();
      chk("rst_outstanding", outstanding, 0);
      chk("rst_mem_valid", bus.mem_valid, 0);
      chk("rst_m0_ready", bus.m0_ready, 0);
      chk("rst_m1_ready", bus.m1_ready, 0);
      chk("rst_rsp_valid", {bus.m0_rsp_valid, bus.m1_rsp_valid}, 0);
      chk("rst_err", err_unexp_rsp, 0);

      // 1: single fetch and its response
      bus.m0_valid = 1'b1; bus.m0_addr = 32'h100; bus.mem_ready = 1'b1;
      settle();
      chk("t1_mem_valid", bus.mem_valid, 1);
      chk("t1_mem_addr", bus.mem_addr, 32'h100);
      chk("t1_mem_we", bus.mem_we, 0);
      chk("t1_mem_wstrb", bus.mem_wstrb, 0);
      chk("t1_m0_ready", bus.m0_ready, 1);
      cyc();
      bus.m0_valid = 1'b0;
      settle();
      chk("t1_outstanding1", outstanding, 1);
      chk("t1_idle_mem_valid", bus.mem_valid, 0);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEADBEEF;
      settle();
      chk("t1_m0_rsp_valid", bus.m0_rsp_valid, 1);
      chk("t1_m0_rsp_data", bus.m0_rsp_data, 32'hDEADBEEF);
      chk("t1_m1_rsp_valid", bus.m1_rsp_valid, 0);
      cyc();
      bus.mem_rsp_valid = 1'b0;
      settle();
      chk("t1_outstanding0", outstanding, 0);

      // 2: round-robin alternation and in-order routing
      do_reset();
      bus.m0_valid = 1'b1; bus.m0_addr = 32'h200;
      bus.m1_valid = 1'b1; bus.m1_addr = 32'h300; bus.m1_we = 1'b0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk($sformatf("t2_m0_ready_%0d", i), bus.m0_ready, (i % 2 == 0));
         chk($sformatf("t2_m1_ready_%0d", i), bus.m1_ready, (i % 2 == 1));
         chk($sformatf("t2_addr_%0d", i), bus.mem_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
         cyc();
      end
      bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
      settle();
      chk("t2_outstanding4", outstanding, 4);
      for (int i = 0; i < 4; i++) begin
         bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = rsp_seq[i];
         settle();
         chk($sformatf("t2_m0_rsp_%0d", i), bus.m0_rsp_valid, (i % 2 == 0));
         chk($sformatf("t2_m1_rsp_%0d", i), bus.m1_rsp_valid, (i % 2 == 1));
         chk($sformatf("t2_rsp_data_%0d", i), (i % 2 == 0) ? bus.m0_rsp_data : bus.m1_rsp_data, rsp_seq[i]);
         cyc();
      end
      bus.mem_rsp_valid = 1'b0;
      settle();
      chk("t2_outstanding0", outstanding, 0);

      // 3: stalled m1 write holds the grant against m0 (rr_ptr now favours m0)
      bus.m1_valid = 1'b1; bus.m1_addr = 32'h20; bus.m1_we = 1'b1;
      bus.m1_wdata = 32'h55AA; bus.m1_wstrb = 4'h3; bus.mem_ready = 1'b0;
      settle();
      chk("t3_mem_we", bus.mem_we, 1);
      chk("t3_m1_ready_stall0", bus.m1_ready, 0);
      cyc();
      bus.m0_valid = 1'b1; bus.m0_addr = 32'h400;
      for (int i = 1; i < 3; i++) begin
         settle();
         chk($sformatf("t3_addr_%0d", i), bus.mem_addr, 32'h20);
         chk($sformatf("t3_wdata_%0d", i), bus.mem_wdata, 32'h55AA);
         chk($sformatf("t3_wstrb_%0d", i), bus.mem_wstrb, 4'h3);
         chk($sformatf("t3_m0_ready_%0d", i), bus.m0_ready, 0);
         chk($sformatf("t3_mem_valid_%0d", i), bus.mem_valid, 1);
         cyc();
      end
      bus.mem_ready = 1'b1;
      settle();
      chk("t3_m1_ready", bus.m1_ready, 1);
      chk("t3_m0_ready_hs", bus.m0_ready, 0);
      cyc();
      bus.m1_valid = 1'b0; bus.m1_we = 1'b0;
      settle();
      chk("t3_m0_next", bus.m0_ready, 1);
      chk("t3_m0_addr", bus.mem_addr, 32'h400);
      chk("t3_m0_we", bus.mem_we, 0);
      chk("t3_m0_wdata", bus.mem_wdata, 0);
      cyc();
      bus.m0_valid = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0;
      settle();
      chk("t3_ack_m1", bus.m1_rsp_valid, 1);
      chk("t3_ack_m0_quiet", bus.m0_rsp_valid, 0);
      cyc();
      bus.mem_rsp_data = 32'h77;
      settle();
      chk("t3_rsp_m0", bus.m0_rsp_valid, 1);
      cyc();
      bus.mem_rsp_valid = 1'b0;
      settle();
      chk("t3_outstanding0", outstanding, 0);

      // 4: fill the ID FIFO, then pop with a pending push
      bus.m0_valid = 1'b1; bus.m0_addr = 32'h500; bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk($sformatf("t4_accept_%0d", i), bus.m0_ready, 1);
         cyc();
      end
      settle();
      chk("t4_full_mem_valid", bus.mem_valid, 0);
      chk("t4_full_m0_ready", bus.m0_ready, 0);
      chk("t4_outstanding4", outstanding, 4);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234;
      settle();
      chk("t4_pop_rsp", bus.m0_rsp_valid, 1);
      chk("t4_pop_no_accept", bus.m0_ready, 0);
      cyc();
      bus.mem_rsp_valid = 1'b0;
      settle();
      chk("t4_outstanding3", outstanding, 3);
      chk("t4_resume", bus.m0_ready, 1);
      cyc();
      bus.m0_valid = 1'b0;
      settle();
      chk("t4_outstanding_refill", outstanding, 4);
      bus.mem_rsp_valid = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      bus.mem_rsp_valid = 1'b0;
      settle();
      chk("t4_drained", outstanding, 0);
      chk("t4_no_err", err_unexp_rsp, 0);

      // 5: unexpected response
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD;
      settle();
      chk("t5_no_rsp", {bus.m0_rsp_valid, bus.m1_rsp_valid}, 0);
      cyc();
      bus.mem_rsp_valid = 1'b0;
      settle();
      chk("t5_err_set", err_unexp_rsp, 1);
      chk("t5_outstanding", outstanding, 0);
      cyc();
      chk("t5_err_sticky", err_unexp_rsp, 1);
      do_reset();
      settle();
      chk("t5_err_cleared", err_unexp_rsp, 0);
      chk("t5_outstanding_rst", outstanding, 0);

      // 6: reset while locked on m1 with two outstanding
      bus.m0_valid = 1'b1; bus.m0_addr = 32'h600; bus.mem_ready = 1'b1;
      cyc();
      cyc();
      bus.m0_valid = 1'b0;
      bus.m1_valid = 1'b1; bus.m1_addr = 32'h700; bus.mem_ready = 1'b0;
      cyc();
      bus.m0_valid = 1'b1;
      settle();
      chk("t6_outstanding2", outstanding, 2);
      chk("t6_locked_addr", bus.mem_addr, 32'h700);
      do_reset();
      bus.mem_ready = 1'b1;
      settle();
      chk("t6_outstanding_rst", outstanding, 0);
      chk("t6_m0_first", bus.m0_ready, 1);
      chk("t6_m1_waits", bus.m1_ready, 0);
      cyc();
      idle_inputs();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
